// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - display geometry, memory word layout and read latency shared by the VRAM scheduler
package vram_pkg;

  localparam int PIX_W          = 4;
  localparam int PPW            = 4;
  localparam int WORD_W         = PIX_W * PPW;
  localparam int H_ACTIVE       = 1024;
  localparam int V_ACTIVE       = 768;
  localparam int H_LAST         = 1343;
  localparam int V_LAST         = 805;
  localparam int ADDR_W         = 18;
  localparam int WORDS_PER_LINE = H_ACTIVE / PPW;
  localparam int RD_LAT         = 2;

  // Word address of a pixel group within the frame buffer.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [9:0] line, input logic [7:0] group);
    return ADDR_W'(line) * ADDR_W'(WORDS_PER_LINE) + ADDR_W'(group);
  endfunction

endpackage

// File: rtl/pixel_unpacker.sv
// rtl/pixel_unpacker.sv - captures fetched words after the read latency and serialises them into pixels
module pixel_unpacker #(
  parameter int PIX_W = vram_pkg::PIX_W,
  parameter int PPW   = vram_pkg::PPW
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_fetch,
  input  logic [PIX_W*PPW-1:0]   i_rd_data,
  input  logic [$clog2(PPW)-1:0] i_phase,
  input  logic                   i_blank,
  output logic [PIX_W-1:0]       o_pixel
);
  import vram_pkg::*;

  localparam int WORD_BITS = PIX_W * PPW;

  logic [RD_LAT-1:0]    r_fetch_pipe;
  logic [WORD_BITS-1:0] r_next_word;
  logic [WORD_BITS-1:0] r_cur_word;
  logic [PIX_W-1:0]     r_pixel;
  logic [PIX_W-1:0]     w_nibble;

  assign w_nibble = r_cur_word[int'(i_phase)*PIX_W +: PIX_W];
  assign o_pixel  = r_pixel;

  // Clearing the pipe drops any fetch issued before or during reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_fetch_pipe <= '0;
      r_next_word  <= '0;
      r_cur_word   <= '0;
      r_pixel      <= '0;
    end else begin
      r_fetch_pipe <= {r_fetch_pipe[RD_LAT-2:0], i_fetch};
      if (r_fetch_pipe[RD_LAT-1]) begin
        r_next_word <= i_rd_data;
      end
      if (i_phase == {$clog2(PPW){1'b1}}) begin
        r_cur_word <= r_next_word;
      end
      r_pixel <= i_blank ? '0 : w_nibble;
    end
  end

endmodule

// File: rtl/vram_scheduler.sv
// rtl/vram_scheduler.sv - VRAM slot scheduler: display fetch slots plus round-robin writers; VRAM_BLANK_WRITE_EN limits writes to vertical blank
module vram_scheduler #(
  parameter int PIX_W    = vram_pkg::PIX_W,
  parameter int PPW      = vram_pkg::PPW,
  parameter int H_ACTIVE = vram_pkg::H_ACTIVE,
  parameter int V_ACTIVE = vram_pkg::V_ACTIVE,
  parameter int H_LAST   = vram_pkg::H_LAST,
  parameter int V_LAST   = vram_pkg::V_LAST,
  parameter int ADDR_W   = vram_pkg::ADDR_W
) (
  input  logic                 vclock,
  input  logic                 reset,
  input  logic [10:0]          hcount,
  input  logic [9:0]           vcount,
  input  logic                 blank,
  input  logic                 wr_req0,
  input  logic                 wr_req1,
  input  logic [ADDR_W-1:0]    wr_addr0,
  input  logic [ADDR_W-1:0]    wr_addr1,
  input  logic [PIX_W*PPW-1:0] wr_data0,
  input  logic [PIX_W*PPW-1:0] wr_data1,
  output logic                 wr_ack0,
  output logic                 wr_ack1,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic [PIX_W*PPW-1:0] mem_din,
  input  logic [PIX_W*PPW-1:0] mem_dout,
  output logic [PIX_W-1:0]     pixel
);
  import vram_pkg::*;

  localparam int FETCH_H_END = H_ACTIVE - PPW;
  localparam int PREFETCH_H  = H_LAST + 1 - PPW;

  logic              w_phase0;
  logic              w_act_fetch;
  logic              w_pre_fetch;
  logic              w_slot;
  logic [9:0]        w_next_line;
  logic [ADDR_W-1:0] w_fetch_addr;
  logic              w_wr_ok;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              r_rr;

  // Slot at group g of a line fetches group g+1; the last phase-0 of the line prefetches group 0 of the next.
  always_comb begin
    w_phase0     = (hcount[1:0] == 2'd0);
    w_next_line  = (vcount == 10'(V_LAST)) ? 10'd0 : vcount + 10'd1;
    w_act_fetch  = w_phase0 && (hcount < 11'(FETCH_H_END)) && (vcount < 10'(V_ACTIVE));
    w_pre_fetch  = w_phase0 && (hcount == 11'(PREFETCH_H)) && (w_next_line < 10'(V_ACTIVE));
    w_slot       = w_act_fetch || w_pre_fetch;
    w_fetch_addr = w_act_fetch ? ADDR_W'(word_addr(vcount, hcount[9:2] + 8'd1))
                               : ADDR_W'(word_addr(w_next_line, 8'd0));
  end

  always_comb begin
`ifdef VRAM_BLANK_WRITE_EN
    w_wr_ok = !reset && !w_slot && (vcount >= 10'(V_ACTIVE));
`else
    w_wr_ok = !reset && !w_slot;
`endif
    // r_rr names the writer that wins a tie.
    w_gnt0 = w_wr_ok && wr_req0 && (!wr_req1 || !r_rr);
    w_gnt1 = w_wr_ok && wr_req1 && (!wr_req0 ||  r_rr);
  end

  always_comb begin
    wr_ack0  = w_gnt0;
    wr_ack1  = w_gnt1;
    mem_we   = w_gnt0 || w_gnt1;
    mem_din  = w_gnt1 ? wr_data1 : wr_data0;
    mem_addr = w_slot ? w_fetch_addr : (w_gnt1 ? wr_addr1 : wr_addr0);
  end

  always_ff @(posedge vclock) begin
    if (reset) begin
      r_rr <= 1'b0;
    end else if (w_gnt0) begin
      r_rr <= 1'b1;
    end else if (w_gnt1) begin
      r_rr <= 1'b0;
    end
  end

  pixel_unpacker #(
    .PIX_W (PIX_W),
    .PPW   (PPW)
  ) u_unpacker (
    .i_clk     (vclock),
    .i_reset   (reset),
    .i_fetch   (w_slot),
    .i_rd_data (mem_dout),
    .i_phase   (hcount[1:0]),
    .i_blank   (blank),
    .o_pixel   (pixel)
  );

endmodule

// File: tb/tb_vram_scheduler.sv
// tb/tb_vram_scheduler.sv - directed bench for vram_scheduler; honours VRAM_BLANK_WRITE_EN
module tb_vram_scheduler;

  logic        vclock = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic        blank = 1'b1;
  logic        wr_req0 = 1'b0;
  logic        wr_req1 = 1'b0;
  logic [17:0] wr_addr0 = 18'h2ABCD;
  logic [17:0] wr_addr1 = 18'h30000;
  logic [15:0] wr_data0 = 16'h1234;
  logic [15:0] wr_data1 = 16'hBEEF;
  logic        wr_ack0;
  logic        wr_ack1;
  logic [17:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_din;
  logic [15:0] mem_dout;
  logic [3:0]  pixel;

  logic [17:0] r_a1, r_a2;
  int n_cmp = 0;
  int n_bad = 0;

`ifdef VRAM_BLANK_WRITE_EN
  localparam bit BLANK_ONLY = 1'b1;
`else
  localparam bit BLANK_ONLY = 1'b0;
`endif

  localparam logic [1:0] ACK_PAT [0:8] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b00};

  vram_scheduler dut (
    .vclock   (vclock),
    .reset    (reset),
    .hcount   (hcount),
    .vcount   (vcount),
    .blank    (blank),
    .wr_req0  (wr_req0),
    .wr_req1  (wr_req1),
    .wr_addr0 (wr_addr0),
    .wr_addr1 (wr_addr1),
    .wr_data0 (wr_data0),
    .wr_data1 (wr_data1),
    .wr_ack0  (wr_ack0),
    .wr_ack1  (wr_ack1),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .pixel    (pixel)
  );

  always #5 vclock = ~vclock;

  // Two-cycle read memory: word 1280 holds DCBA, every other word returns its own address.
  always @(posedge vclock) begin
    r_a1 <= mem_addr;
    r_a2 <= r_a1;
  end
  assign mem_dout = (r_a2 == 18'd1280) ? 16'hDCBA : r_a2[15:0];

  task automatic cyc(input int h, input int v, input bit b, input bit rst, input bit r0, input bit r1);
    @(negedge vclock);
    hcount  = 11'(h);
    vcount  = 10'(v);
    blank   = b;
    reset   = rst;
    wr_req0 = r0;
    wr_req1 = r1;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    // Reset mid-line with both writers requesting.
    cyc(500, 10, 0, 1, 1, 1);
    cyc(501, 10, 0, 1, 1, 1);
    check("rst_pixel", 32'(pixel), 32'h0);
    check("rst_acks", 32'({wr_ack1, wr_ack0}), 32'h0);
    check("rst_we", 32'(mem_we), 32'h0);

    // A fetch issued in the last reset cycle must never reach the pixels.
    cyc(0, 5, 0, 1, 0, 0);
    cyc(1, 5, 0, 0, 0, 0);
    check("rst_pix_after", 32'(pixel), 32'h0);
    cyc(2, 5, 0, 0, 0, 0);
    cyc(3, 5, 0, 0, 0, 0);
    cyc(4, 5, 0, 0, 0, 0);
    cyc(5, 5, 0, 0, 0, 0);
    check("rst_flush", 32'(pixel), 32'h0);

    // Prefetch of line 5 at the end of line 4, then in-line fetches.
    cyc(1340, 4, 1, 0, 0, 0);
    check("prefetch_addr", 32'(mem_addr), 32'd1280);
    check("prefetch_we", 32'(mem_we), 32'h0);
    cyc(1341, 4, 1, 0, 0, 0);
    cyc(1342, 4, 1, 0, 0, 0);
    cyc(1343, 4, 1, 0, 0, 0);
    cyc(0, 5, 0, 0, 0, 0);
    check("fetch_h0", 32'(mem_addr), 32'd1281);
    cyc(1, 5, 0, 0, 0, 0);
    check("pix_h0", 32'(pixel), 32'hA);
    cyc(2, 5, 0, 0, 0, 0);
    check("pix_h1", 32'(pixel), 32'hB);
    cyc(3, 5, 0, 0, 0, 0);
    check("pix_h2", 32'(pixel), 32'hC);
    cyc(4, 5, 0, 0, 0, 0);
    check("pix_h3", 32'(pixel), 32'hD);
    check("fetch_h4", 32'(mem_addr), 32'd1282);
    cyc(5, 5, 0, 0, 0, 0);
    check("pix_h4", 32'(pixel), 32'h1);
    cyc(6, 5, 0, 0, 0, 0);
    cyc(7, 5, 0, 0, 0, 0);
    cyc(8, 5, 0, 0, 0, 0);
    check("fetch_h8", 32'(mem_addr), 32'd1283);
    cyc(9, 5, 0, 0, 0, 0);
    check("pix_h8", 32'(pixel), 32'h2);
    cyc(10, 5, 1, 0, 0, 0);
    cyc(11, 5, 0, 0, 0, 0);
    check("pix_blank", 32'(pixel), 32'h0);

    // Both writers contend from the start of an active line.
    for (int h = 0; h <= 8; h++) begin
      cyc(h, 6, 0, 0, 1, 1);
      check("rr_acks", 32'({wr_ack1, wr_ack0}), 32'(ACK_PAT[h]));
      if (h == 0) check("rr_fetch_addr", 32'(mem_addr), 32'd1537);
      if (h == 1) begin
        check("rr_addr0", 32'(mem_addr), 32'h2ABCD);
        check("rr_din0", 32'(mem_din), 32'h1234);
      end
      if (h == 2) begin
        check("rr_addr1_oor", 32'(mem_addr), 32'h30000);
        check("rr_din1", 32'(mem_din), 32'hBEEF);
        check("rr_we", 32'(mem_we), 32'h1);
      end
    end
    cyc(9, 6, 0, 0, 0, 1);
    check("single_w1", 32'({wr_ack1, wr_ack0}), 32'h2);
    cyc(12, 6, 0, 0, 1, 0);
    check("slot_no_ack", 32'({wr_ack1, wr_ack0}), 32'h0);
    cyc(13, 6, 0, 0, 0, 0);
    check("withdrawn_we", 32'(mem_we), 32'h0);

    // Frame wrap prefetch and the unused slot before vertical blank.
    cyc(1340, 805, 1, 0, 0, 0);
    check("wrap_addr", 32'(mem_addr), 32'd0);
    check("wrap_we", 32'(mem_we), 32'h0);
    cyc(1340, 767, 1, 0, 1, 0);
    check("l767_we", 32'(mem_we), BLANK_ONLY ? 32'h0 : 32'h1);
    check("l767_ack", 32'(wr_ack0), BLANK_ONLY ? 32'h0 : 32'h1);

    // Write during active video: immediate, or deferred to vertical blank.
    cyc(1, 100, 0, 0, 1, 0);
    check("active_ack", 32'(wr_ack0), BLANK_ONLY ? 32'h0 : 32'h1);
    cyc(1, 767, 0, 0, 1, 0);
    check("l767_h1_ack", 32'(wr_ack0), BLANK_ONLY ? 32'h0 : 32'h1);
    cyc(0, 768, 1, 0, 1, 0);
    check("vblank_ack", 32'(wr_ack0), 32'h1);
    check("vblank_addr", 32'(mem_addr), 32'h2ABCD);
    cyc(1, 768, 1, 0, 0, 0);
    check("vblank_pixel", 32'(pixel), 32'h0);
    check("vblank_we", 32'(mem_we), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vram_scheduler.md
# vram_scheduler

Owns the single-port video RAM behind the 1024x768 @ 60 Hz display timing generator and schedules all accesses to it. Guaranteed display fetches are issued on a fixed 1-in-4 slot derived from hcount/vcount, and the remaining cycles are shared round-robin between two pixel writers. It outputs one registered 4-bit pixel per clock, one cycle behind the timing counters. It sits between the timing generator, the drawing/capture logic and the colour-lookup/output stage.

## Interface
Parameters:
- PIX_W, 4: bits per pixel.
- PPW, 4: pixels per memory word. Word width is PIX_W*PPW = 16.
- H_ACTIVE, 1024: visible pixels per line.
- V_ACTIVE, 768: visible lines.
- H_LAST, 1343: last hcount value of a line.
- V_LAST, 805: last vcount value of a frame.
- ADDR_W, 18: word address width. Address = line*256 + group.

Ports:
- vclock  in  1: pixel clock (65 MHz).
- reset  in  1: synchronous, active-high.
- hcount  in  11, vcount  in  10, blank  in  1: from the timing generator, same cycle.
- wr_req0 / wr_req1  in  1: write request; held until acknowledged.
- wr_addr0 / wr_addr1  in  18: word address.
- wr_data0 / wr_data1  in  16: word data.
- wr_ack0 / wr_ack1  out  1: one-cycle pulse in the cycle the write is issued.
- mem_addr  out  18, mem_we  out  1, mem_din  out  16: combinational memory port drive.
- mem_dout  in  16: read data, valid exactly 2 cycles after its address.
- pixel  out  4: registered; corresponds to the previous cycle's hcount/vcount/blank.

## Operation
- **Display slot:** a cycle is a display slot when hcount[1:0]==0 and one of the following holds.
  - hcount<1020 and vcount<768: fetch group hcount/4+1 of line vcount.
  - hcount==1340: fetch group 0 of the next line (vcount==805 gives line 0; vcount+1 otherwise), only if that line is below 768.
  - In a display slot: mem_we=0 and mem_addr is the fetch address.
- **Fetch capture:**
  - A fetch's data is captured into next_word 2 cycles after issue.
  - next_word is copied into cur_word at every hcount[1:0]==3.
  - pixel <= blank ? 0 : cur_word[hcount[1:0]*4 +: 4]. Pixel 0 is in the low nibble.
- **Write slots:**
  - Any cycle that is not a display slot is write-eligible, subject to the configuration macro.
  - If only one writer requests, it is granted.
  - If both request, the writer not granted most recently wins. The rr pointer toggles only on a grant.
  - On a grant: mem_we=1, mem_addr/mem_din are taken from the winner, and its wr_ack pulses in that same cycle.
  - A writer deasserting its request without an ack is legal. Nothing is issued for it.
- **Reset:**
  - pixel, cur_word, next_word and both acks go to 0. rr pointer points to writer 0.
  - Any fetch in flight is discarded: capture is suppressed for 2 cycles after reset.
  - Pending writes stay un-acked, so requesters retry naturally.

## Timing
- Display has absolute priority. At most 3 of every 4 cycles are free for writes during active lines.
- Guaranteed write bandwidth when both writers contend: at least 1 write per writer per 8 cycles in active region.
- Pixel latency is 1 cycle vs hcount. The top level delays hsync/vsync/blank by 1 register.
- Boundaries:
  - Frame wrap (vcount 805 -> 0): group 0 of line 0 is prefetched at hcount 1340.
  - Lines 767 -> 768: no fetches are issued and pixel is forced 0.
- An out-of-range write address (>= 196608) is issued unchanged. Range checking belongs to the writer.

## Configuration
- VRAM_BLANK_WRITE_EN
  - Defined: writes are granted only while vcount>=V_ACTIVE (vertical blank), giving tear-free updates. Requests during active video wait.
  - Undefined: writes use every non-display slot in any region.

## Structure
- Shared package vram_pkg holds H_ACTIVE, V_ACTIVE, H_LAST, V_LAST, PIX_W, PPW, ADDR_W, the derived WORD_W and WORDS_PER_LINE=256, and the memory read latency constant RD_LAT=2.
- One sub-module, pixel_unpacker: owns next_word/cur_word, the capture delay pipeline and the nibble select. The top owns slot decode and arbitration.

## Test plan
- **Reset:** reset high mid-line -> pixel=0, wr_ack0/1=0, mem_we=0. The first capture occurs no earlier than 3 cycles after reset.
- **Line fetch order:** memory model returns data=addr[15:0].
  - At vcount=5, hcount=1340 of line 4 -> mem_addr=5*256=1280.
  - At hcount=0/4/8 of line 5 -> mem_addr=1281/1282/1283.
- **Pixel output:** word at 1280 = 16'hDCBA -> pixel = A,B,C,D on the cycles after hcount=0,1,2,3 of line 5. pixel=0 whenever blank was 1.
- **Contention:** both writers request continuously from hcount=0 -> acks alternate 0,1,0,... and none is issued at hcount%4==0. Writer 0 gets the first grant after reset.
- **Frame wrap:** vcount=805, hcount=1340 -> mem_addr=0. vcount=767, hcount=1340 -> no fetch, free for writes.
- **VRAM_BLANK_WRITE_EN defined:** wr_req0 raised at vcount=100 -> no ack until vcount=768, hcount=0. Ack occurs on the first non-slot cycle there.
